// File: rtl/pwm_deadtime.sv
// pwm_deadtime: complementary half-bridge gate driver with dead-time insertion.
//
// A raw PWM stream is split into a high-side drive (pwm_h) and a low-side
// drive (pwm_l). Whenever the bridge changes direction, both gates are held
// low for `dead` clock cycles so the two switches are never on together.
// Leaving OFF also inserts a full dead interval before any gate is driven.
//
// Optional feature: define PWM_DEADTIME_FAULT_EN to add a latched FAULT state
// with fault / fault_clr inputs and a fault_flag output.
//
// Every output is registered and decoded from the next state. Because each
// output is active in exactly one state, pwm_h and pwm_l can never be high
// in the same cycle.
module pwm_deadtime #(
    parameter int D = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         pwm_in,
    input  logic [D-1:0] dead,
    output logic         pwm_h,
    output logic         pwm_l,
    output logic         in_dead
`ifdef PWM_DEADTIME_FAULT_EN
    ,
    input  logic         fault,
    input  logic         fault_clr,
    output logic         fault_flag
`endif
);

    localparam logic [2:0] ST_OFF   = 3'd0;
    localparam logic [2:0] ST_HIGH  = 3'd1;
    localparam logic [2:0] ST_LOW   = 3'd2;
    localparam logic [2:0] ST_DEAD  = 3'd3;
`ifdef PWM_DEADTIME_FAULT_EN
    localparam logic [2:0] ST_FAULT = 3'd4;
`endif

    localparam logic [D-1:0] CNT_ZERO = {D{1'b0}};
    localparam logic [D-1:0] CNT_ONE  = {{(D-1){1'b0}}, 1'b1};

    logic [2:0]   state_r;
    logic [2:0]   state_s;
    logic [D-1:0] cnt_r;
    logic [D-1:0] cnt_s;
    logic         dead_zero_s;

    assign dead_zero_s = (dead == CNT_ZERO);

    // Next-state and dead-time counter logic (fault > enable > normal operation).
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
`ifdef PWM_DEADTIME_FAULT_EN
        if (fault) begin
            state_s = ST_FAULT;
            cnt_s   = CNT_ZERO;
        end else if (state_r == ST_FAULT) begin
            // Latched until explicitly cleared while the fault is gone.
            cnt_s = CNT_ZERO;
            if (fault_clr) begin
                state_s = ST_OFF;
            end else begin
                state_s = ST_FAULT;
            end
        end else
`endif
        if (!enable) begin
            state_s = ST_OFF;
            cnt_s   = CNT_ZERO;
        end else begin
            case (state_r)
                ST_OFF: begin
                    // Startup always begins with a full dead interval.
                    if (dead_zero_s) begin
                        state_s = pwm_in ? ST_HIGH : ST_LOW;
                        cnt_s   = CNT_ZERO;
                    end else begin
                        state_s = ST_DEAD;
                        cnt_s   = dead;
                    end
                end
                ST_HIGH: begin
                    if (pwm_in) begin
                        state_s = ST_HIGH;
                    end else if (dead_zero_s) begin
                        state_s = ST_LOW;
                    end else begin
                        state_s = ST_DEAD;
                        cnt_s   = dead;
                    end
                end
                ST_LOW: begin
                    if (!pwm_in) begin
                        state_s = ST_LOW;
                    end else if (dead_zero_s) begin
                        state_s = ST_HIGH;
                    end else begin
                        state_s = ST_DEAD;
                        cnt_s   = dead;
                    end
                end
                ST_DEAD: begin
                    // pwm_in is only looked at on the expiry edge; a count of
                    // zero cannot normally occur here but is treated as expired.
                    if (cnt_r <= CNT_ONE) begin
                        state_s = pwm_in ? ST_HIGH : ST_LOW;
                        cnt_s   = CNT_ZERO;
                    end else begin
                        state_s = ST_DEAD;
                        cnt_s   = cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    state_s = ST_OFF;
                    cnt_s   = CNT_ZERO;
                end
            endcase
        end
    end

    // State, counter and registered gate outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_OFF;
            cnt_r      <= CNT_ZERO;
            pwm_h      <= 1'b0;
            pwm_l      <= 1'b0;
            in_dead    <= 1'b0;
`ifdef PWM_DEADTIME_FAULT_EN
            fault_flag <= 1'b0;
`endif
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            pwm_h      <= (state_s == ST_HIGH);
            pwm_l      <= (state_s == ST_LOW);
            in_dead    <= (state_s == ST_DEAD);
`ifdef PWM_DEADTIME_FAULT_EN
            fault_flag <= (state_s == ST_FAULT);
`endif
        end
    end

endmodule

// File: doc/pwm_deadtime.md
PWM_DEADTIME -- requirements
Module: pwm_deadtime

Interface
REQ-001 SHALL have parameter D, default 8, width of the dead-time setting and internal dead-time counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port enable  input  1  1 = drive the bridge, 0 = force both outputs low.
REQ-005 SHALL have port pwm_in  input  1  raw PWM from the upstream PWM generator, synchronous to clk.
REQ-006 SHALL have port dead  input  D  dead-time length in clk cycles, unsigned.
REQ-007 SHALL have port pwm_h  output  1  registered high-side gate drive.
REQ-008 SHALL have port pwm_l  output  1  registered low-side gate drive.
REQ-009 SHALL have port in_dead  output  1  registered; high while in dead-time interval.

Function
REQ-010 SHALL implement FSM states OFF, HIGH, LOW, DEAD; pwm_h=1 only in HIGH, pwm_l=1 only in LOW, both 0 in OFF and DEAD; in_dead=1 only in DEAD.
REQ-011 SHALL never assert pwm_h and pwm_l in the same cycle, under any input sequence.
REQ-012 SHALL, in OFF with enable=1, enter DEAD with counter loaded from dead (startup dead time), or enter HIGH/LOW per pwm_in directly if dead=0.
REQ-013 SHALL, in HIGH with pwm_in=0 (or LOW with pwm_in=1), enter DEAD with counter loaded from dead on that edge; if dead=0, switch directly to LOW (HIGH) on that edge.
REQ-014 SHALL, in DEAD, decrement the counter each edge; on the edge where counter=1, leave DEAD to HIGH if pwm_in=1, else LOW; both outputs low for exactly dead cycles.
REQ-015 SHALL sample dead only when loading the counter; changes to dead during DEAD do not alter the current interval.
REQ-016 SHALL ignore pwm_in toggles during DEAD (counter not restarted); exit state chosen from pwm_in on the expiry edge only.
REQ-017 SHALL, with enable=0, go to OFF on the next edge from any state, abandoning any dead-time count (counter cleared).
REQ-018 SHALL have latency of 1 clk from pwm_in edge to the falling output (registered), and 1+dead clk to the rising complementary output.
REQ-019 SHALL, with pwm_in constant, hold HIGH or LOW indefinitely (100% / 0% duty pass through, no dead-time insertion).

Reset
REQ-020 SHALL, with reset=1 at a clock edge, set state OFF, counter 0, pwm_h=0, pwm_l=0, in_dead=0; reset has priority over enable and fault.
REQ-021 SHALL, after reset deasserts with enable=1, apply the full startup dead time of REQ-012 before any output asserts.

Configuration
REQ-022 SHALL, when macro PWM_DEADTIME_FAULT_EN is defined, add inputs fault (1 bit) and fault_clr (1 bit), output fault_flag (1 bit, reset 0), and state FAULT.
REQ-023 SHALL, with PWM_DEADTIME_FAULT_EN defined, enter FAULT from any state on the edge fault=1 is sampled: pwm_h=pwm_l=0, fault_flag=1 on that edge; fault has priority over enable.
REQ-024 SHALL, with PWM_DEADTIME_FAULT_EN defined, leave FAULT to OFF only on an edge with fault=0 and fault_clr=1, clearing fault_flag; fault_clr while fault=1 is ignored.
REQ-025 SHALL, without PWM_DEADTIME_FAULT_EN, omit fault, fault_clr, fault_flag and FAULT entirely; behaviour otherwise identical.

Verification
REQ-026 SHALL cover: reset, enable=1, dead=4, pwm_in=1 -> pwm_h rises 4 cycles after first enabled edge, pwm_l stays 0.
REQ-027 SHALL cover: dead=3, pwm_in 1->0 in HIGH -> pwm_h=0 next cycle, in_dead=1 for 3 cycles, pwm_l=1 after; mirror test for 0->1.
REQ-028 SHALL cover: dead=5, 2-cycle low glitch on pwm_in during HIGH -> 5 dead cycles then HIGH resumes, no pwm_l pulse.
REQ-029 SHALL cover: dead=0, pwm_in square wave period 8 -> outputs exact complements with 1-cycle delay, never both high.
REQ-030 SHALL cover: enable dropped mid-DEAD and reset asserted mid-HIGH -> both outputs 0 next edge, restart applies full dead time.
REQ-031 SHALL cover (PWM_DEADTIME_FAULT_EN): fault=1 during HIGH -> outputs 0 and fault_flag=1 next edge; fault_clr with fault=1 ignored; fault=0, fault_clr=1 -> OFF, flag 0.
